// File: rtl/lnrv_itcm_slv_pkg.sv
// rtl/lnrv_itcm_slv_pkg.sv - shared size encodings, response type and size check for the ITCM slave
//
// Purpose: definitions shared by the ITCM responder and its response queue.
//   SIZE_*   : cmd_size encodings (byte/half/word; anything above word is illegal)
//   rsp_t    : one queued response {err, rdata}
//   size_err : alignment / legality check of a command size against the low address bits
package lnrv_itcm_slv_pkg;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

  function automatic logic size_err(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: size_err = 1'b0;
      SIZE_HALF: size_err = lo[0];
      SIZE_WORD: size_err = (lo != 2'b00);
      default:   size_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lnrv_sync_fifo.sv
// rtl/lnrv_sync_fifo.sv - non-bypass synchronous FIFO with registered storage and occupancy count
//
// Purpose: in-order response queue. A pushed entry is visible on dout the cycle after the push,
//          even when the queue was empty (no bypass).
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, din       : write strobe and entry
//   pop             : read strobe (ignored when empty)
//   dout, vld       : head entry and non-empty flag
//   count           : number of entries held
module lnrv_sync_fifo #(
  parameter int  WIDTH = 33,
  parameter int  DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic [CW-1:0]    count
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign vld     = (count != '0);
  assign do_pop  = pop & vld;
  // A push into a full queue is only taken when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
      if (do_pop)  rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  overflow_never: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/lnrv_itcm_slv.sv
// rtl/lnrv_itcm_slv.sv - ITCM responder on the lnrv cmd/rsp bus driving a single-port SRAM
//
// Purpose: decodes bus commands, checks range and alignment, drives the SRAM in the accept
//          cycle and returns in-order responses through a credit-limited queue.
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   cmd_vld/cmd_rdy                     : command handshake
//   cmd_write/addr/wdata/wstrb/size     : command fields
//   rsp_vld/rsp_rdy/rsp_rdata/rsp_err   : response handshake and payload
//   ram_cs/we/addr/wdata/wem, ram_rdata : SRAM macro interface (read data one cycle after cs)
module lnrv_itcm_slv
  import lnrv_itcm_slv_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RSP_DEPTH   = 3,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic          cmd_write,
  input  logic [31:0]   cmd_addr,
  input  logic [31:0]   cmd_wdata,
  input  logic [3:0]    cmd_wstrb,
  input  logic [2:0]    cmd_size,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_wem,
  input  logic [31:0]   ram_rdata
);

  localparam int            CW        = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] MAX_OUT   = CW'(RSP_DEPTH);
  localparam logic [31:0]   WIN_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]   off;
  logic          cmd_err;
  logic          accept;
  logic          pop;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] q_count;
  logic          fl_vld;
  logic          fl_read;
  logic          fl_err;
  rsp_t          push_data;
  rsp_t          q_data;

  // Unsigned offset: addresses below the base wrap high and fail the range check.
  assign off     = cmd_addr - ADDR_BASE;
  assign cmd_err = (off >= WIN_BYTES) | size_err(cmd_size, cmd_addr[1:0]);

  // Credits count every accepted command until its response is popped, so the queue
  // can never be asked to hold more than RSP_DEPTH entries.
  assign cmd_rdy = ~reset & (outstanding < MAX_OUT);
  assign accept  = cmd_vld & cmd_rdy;
  assign pop     = rsp_vld & rsp_rdy;

  assign ram_cs    = accept & ~cmd_err;
  assign ram_we    = ram_cs & cmd_write;
  assign ram_addr  = off[AW+1:2];
  assign ram_wdata = cmd_wdata;
  assign ram_wem   = ram_we ? cmd_wstrb : 4'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fl_vld  <= 1'b0;
      fl_read <= 1'b0;
      fl_err  <= 1'b0;
    end else begin
      fl_vld <= accept;
      if (accept) begin
        fl_read <= ~cmd_write;
        fl_err  <= cmd_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // SRAM read data is valid exactly while the in-flight entry is being pushed.
  assign push_data = {fl_err, (fl_read & ~fl_err) ? ram_rdata : 32'h0};

  lnrv_sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_q (
    .clk   (clk),
    .reset (reset),
    .push  (fl_vld),
    .din   (push_data),
    .pop   (pop),
    .dout  (q_data),
    .vld   (rsp_vld),
    .count (q_count)
  );

  assign rsp_rdata = q_data.rdata;
  assign rsp_err   = q_data.err;

  credits_match: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, q_count} + {{CW{1'b0}}, fl_vld}) == {1'b0, outstanding});

endmodule

// File: tb/tb_lnrv_itcm_slv.sv
// tb/tb_lnrv_itcm_slv.sv - self-checking bench for the ITCM responder
module tb_lnrv_itcm_slv;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DW   = 4096;

  logic        clk;
  logic        reset;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [2:0]  cmd_size;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_cs;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wem;
  logic [31:0] ram_rdata;

  lnrv_itcm_slv dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .cmd_size  (cmd_size),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wem   (ram_wem),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: byte-masked write, registered read.
  logic [31:0] sram [DW];
  initial for (int i = 0; i < DW; i++) sram[i] = 32'h0;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= sram[ram_addr];
      end
    end
  end

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  sz;
  } cmd_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } rsp_e;

  cmd_t        pend[$];
  rsp_e        expq[$];
  int          popq[$];
  logic [31:0] ref_mem [DW];

  int          n_vec;
  int          n_miss;
  int          cyc;
  int          acc_cnt;
  int          stall_cnt;
  bit          saw_cs;
  bit          prev_stall;
  bit          rdy_rand;
  logic [31:0] prev_rdata;
  logic        prev_err;

  logic        s_acc;
  logic        s_cmd_rdy;
  logic        s_ram_cs;
  logic        s_ram_we;
  logic [11:0] s_ram_addr;
  logic [3:0]  s_ram_wem;
  logic        s_rsp_vld;
  logic [31:0] s_rsp_rdata;
  logic        s_rsp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] o;
    o = a - BASE;
    if (sz > 3'd2) return 1'b1;
    if (o >= 32'(DW * 4)) return 1'b1;
    if (sz == 3'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 3'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_accept();
    rsp_e        e;
    logic [31:0] o;
    int          idx;
    o     = cmd_addr - BASE;
    e.err = ref_err(cmd_addr, cmd_size);
    e.rd  = 32'h0;
    if (!e.err) begin
      idx = int'(o / 4);
      if (cmd_write) begin
        for (int b = 0; b < 4; b++)
          if (cmd_wstrb[b]) ref_mem[idx][8*b +: 8] = cmd_wdata[8*b +: 8];
      end else begin
        e.rd = ref_mem[idx];
      end
    end
    expq.push_back(e);
  endtask

  // One clock: sample everything at the falling edge, score responses, model accepts,
  // then return just after the next rising edge so the caller can drive new inputs.
  task automatic tick();
    rsp_e e;
    @(negedge clk);
    s_acc       = cmd_vld & cmd_rdy;
    s_cmd_rdy   = cmd_rdy;
    s_ram_cs    = ram_cs;
    s_ram_we    = ram_we;
    s_ram_addr  = ram_addr;
    s_ram_wem   = ram_wem;
    s_rsp_vld   = rsp_vld;
    s_rsp_rdata = rsp_rdata;
    s_rsp_err   = rsp_err;
    if (ram_cs) saw_cs = 1'b1;
    if (cmd_vld && !cmd_rdy) stall_cnt++;
    if (prev_stall) begin
      check("hold_vld", {31'd0, rsp_vld}, 32'd1);
      check("hold_rdata", rsp_rdata, prev_rdata);
      check("hold_err", {31'd0, rsp_err}, {31'd0, prev_err});
    end
    if (rsp_vld && rsp_rdy) begin
      check("rsp_expected", {31'd0, expq.size() > 0}, 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("rsp_rdata", rsp_rdata, e.rd);
      end
      popq.push_back(cyc);
    end
    prev_stall = rsp_vld && !rsp_rdy;
    prev_rdata = rsp_rdata;
    prev_err   = rsp_err;
    if (s_acc) begin
      acc_cnt++;
      model_accept();
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input cmd_t c);
    cmd_vld   = 1'b1;
    cmd_write = c.w;
    cmd_addr  = c.a;
    cmd_wdata = c.d;
    cmd_wstrb = c.s;
    cmd_size  = c.sz;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (pend.size() > 0) drive(pend[0]);
      else cmd_vld = 1'b0;
      if (rdy_rand) rsp_rdy = 1'($urandom_range(0, 1));
      tick();
      if (s_acc && pend.size() > 0) void'(pend.pop_front());
    end
    cmd_vld = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((pend.size() != 0 || expq.size() != 0) && n < limit) begin
      run(1);
      n++;
    end
    check("drain_done", 32'(pend.size() + expq.size()), 32'd0);
  endtask

  function automatic cmd_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [2:0] sz);
    cmd_t c;
    c.w = w; c.a = a; c.d = d; c.s = s; c.sz = sz;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_t        c;
    int          a0;
    int          r;
    logic [1:0]  lo;

    n_vec = 0; n_miss = 0; cyc = 0; acc_cnt = 0; stall_cnt = 0;
    saw_cs = 1'b0; prev_stall = 1'b0; rdy_rand = 1'b0;
    prev_rdata = 32'h0; prev_err = 1'b0;
    for (int i = 0; i < DW; i++) ref_mem[i] = 32'h0;
    ram_rdata = 32'h0;

    // 1. reset: a valid command presented during reset must not reach the SRAM
    reset   = 1'b1;
    rsp_rdy = 1'b1;
    drive(mk(1'b0, BASE + 32'h20, 32'h0, 4'h0, 3'd2));
    tick();
    tick();
    check("reset_cmd_rdy", {31'd0, s_cmd_rdy}, 32'd0);
    check("reset_rsp_vld", {31'd0, s_rsp_vld}, 32'd0);
    check("reset_ram_cs", {31'd0, s_ram_cs}, 32'd0);
    cmd_vld = 1'b0;
    reset   = 1'b0;
    tick();
    check("release_cmd_rdy", {31'd0, s_cmd_rdy}, 32'd1);

    // 2. word write then read, with latency N+2
    drive(mk(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2));
    tick();
    check("wr_accept", {31'd0, s_acc}, 32'd1);
    check("wr_ram_cs", {31'd0, s_ram_cs}, 32'd1);
    check("wr_ram_we", {31'd0, s_ram_we}, 32'd1);
    check("wr_ram_addr", {20'd0, s_ram_addr}, 32'd4);
    check("wr_ram_wem", {28'd0, s_ram_wem}, 32'hF);
    cmd_vld = 1'b0;
    tick();
    check("wr_rsp_n1", {31'd0, s_rsp_vld}, 32'd0);
    tick();
    check("wr_rsp_n2", {31'd0, s_rsp_vld}, 32'd1);
    check("wr_rsp_err", {31'd0, s_rsp_err}, 32'd0);
    drive(mk(1'b0, 32'h8000_0010, 32'h0, 4'h0, 3'd2));
    tick();
    check("rd_ram_we", {31'd0, s_ram_we}, 32'd0);
    check("rd_ram_wem", {28'd0, s_ram_wem}, 32'h0);
    cmd_vld = 1'b0;
    tick();
    check("rd_rsp_n1", {31'd0, s_rsp_vld}, 32'd0);
    tick();
    check("rd_rsp_n2", {31'd0, s_rsp_vld}, 32'd1);
    check("rd_rsp_data", s_rsp_rdata, 32'hDEAD_BEEF);

    // write with no strobes is a legal, error-free SRAM access that changes nothing
    drive(mk(1'b1, 32'h8000_0010, 32'h1234_5678, 4'h0, 3'd2));
    tick();
    check("wz_ram_cs", {31'd0, s_ram_cs}, 32'd1);
    check("wz_ram_wem", {28'd0, s_ram_wem}, 32'h0);
    cmd_vld = 1'b0;
    pend.push_back(mk(1'b0, 32'h8000_0010, 32'h0, 4'h0, 3'd2));
    drain(20);

    // 3. error cases never touch the SRAM
    saw_cs = 1'b0;
    pend.push_back(mk(1'b0, 32'h8000_4000, 32'h0, 4'h0, 3'd2));
    pend.push_back(mk(1'b0, 32'h8000_0002, 32'h0, 4'h0, 3'd2));
    pend.push_back(mk(1'b0, 32'h8000_0001, 32'h0, 4'h0, 3'd1));
    pend.push_back(mk(1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'd3));
    pend.push_back(mk(1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 3'd2));
    drain(40);
    check("err_no_ram_cs", {31'd0, saw_cs}, 32'd0);

    // 4. back-pressure: only RSP_DEPTH commands accepted while responses are held
    rsp_rdy = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 5; i++)
      pend.push_back(mk(1'b0, BASE + 32'($urandom_range(0, 15) * 4), 32'h0, 4'h0, 3'd2));
    run(8);
    check("bp_accepted", 32'(acc_cnt - a0), 32'd3);
    check("bp_cmd_rdy", {31'd0, s_cmd_rdy}, 32'd0);
    check("bp_rsp_vld", {31'd0, s_rsp_vld}, 32'd1);
    rsp_rdy = 1'b1;
    drain(40);
    check("bp_total", 32'(acc_cnt - a0), 32'd5);

    // random traffic with random response back-pressure
    for (int i = 0; i < 60; i++) begin
      r    = $urandom_range(0, 11);
      c.w  = 1'($urandom_range(0, 1));
      c.sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      lo   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (c.sz == 3'd1) lo = lo & 2'b10;
        else if (c.sz == 3'd2) lo = 2'b00;
      end
      if (r == 0)      c.a = 32'h8000_4000 + 32'($urandom_range(0, 3) * 4) + 32'(lo);
      else if (r == 1) c.a = 32'h7FFF_FFF0 + 32'(lo);
      else if (r == 2) c.a = BASE + 32'((DW - 1) * 4) + 32'(lo);
      else             c.a = BASE + 32'($urandom_range(0, 15) * 4) + 32'(lo);
      c.d = $urandom;
      c.s = 4'($urandom);
      pend.push_back(c);
    end
    rdy_rand = 1'b1;
    drain(800);
    rdy_rand = 1'b0;
    rsp_rdy  = 1'b1;

    // 5. streaming: 16 back-to-back reads, one response per cycle
    stall_cnt = 0;
    popq.delete();
    for (int i = 0; i < 16; i++)
      pend.push_back(mk(1'b0, BASE + 32'(i * 4), 32'h0, 4'h0, 3'd2));
    drain(60);
    check("stream_no_stall", 32'(stall_cnt), 32'd0);
    check("stream_count", 32'(popq.size()), 32'd16);
    if (popq.size() == 16)
      check("stream_span", 32'(popq[15] - popq[0]), 32'd15);

    // 6. reset with responses queued
    rsp_rdy = 1'b0;
    pend.push_back(mk(1'b0, BASE + 32'h10, 32'h0, 4'h0, 3'd2));
    pend.push_back(mk(1'b0, BASE + 32'h14, 32'h0, 4'h0, 3'd2));
    run(5);
    check("pre_rst_rsp_vld", {31'd0, s_rsp_vld}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_rsp_vld_now", {31'd0, rsp_vld}, 32'd0);
    check("rst_cmd_rdy_now", {31'd0, cmd_rdy}, 32'd0);
    expq.delete();
    pend.delete();
    prev_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_rsp", {31'd0, s_rsp_vld}, 32'd0);
    end
    a0 = acc_cnt;
    for (int i = 0; i < 3; i++)
      pend.push_back(mk(1'b0, BASE + 32'($urandom_range(0, 15) * 4), 32'h0, 4'h0, 3'd2));
    run(6);
    check("post_rst_credits", 32'(acc_cnt - a0), 32'd3);
    rsp_rdy = 1'b1;
    drain(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
